l2_flatten: RTL

//  Layer-2 flatten stage, directly downstream of the convolution/max-pool engine.

---
 rtl/l2_flatten.sv | 131 +++++++++++++
 1 files changed

// File: rtl/l2_flatten.sv
// Layer-2 flatten: reads the two 32x32 max-pool planes over the shared memory bus and writes them interleaved.
// Optional feature macro: L2_FLATTEN_CHKSUM_EN adds a 32-bit running sum of all written words.
module l2_flatten #(
  parameter logic [2:0] SRC0_SEL = 3'b011,
  parameter logic [2:0] SRC1_SEL = 3'b100,
  parameter logic [2:0] DST_SEL  = 3'b101,
  parameter int         NPIX     = 1024,
  parameter int         AW       = 12,
  parameter int         DW       = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
`ifdef L2_FLATTEN_CHKSUM_EN
  ,
  output logic [31:0]   chksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_WR0,
    S_WR1,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);
  localparam logic [AW-1:0] PIX_ONE  = AW'(1);

  state_t        state_reg;
  logic [AW-1:0] pix_reg;
  logic [DW-1:0] d0_reg;
  logic [DW-1:0] d1_reg;

  // Every output is loaded on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      pix_reg   <= '0;
      d0_reg    <= '0;
      d1_reg    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crd       <= 1'b0;
      cwr       <= 1'b0;
      caddr_rd  <= '0;
      caddr_wr  <= '0;
      cdata_wr  <= '0;
      csel      <= 3'b000;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_RD0;
            busy      <= 1'b1;
            crd       <= 1'b1;
            csel      <= SRC0_SEL;
            caddr_rd  <= pix_reg;
          end
        end
        S_RD0: begin
          d0_reg    <= cdata_rd;
          state_reg <= S_RD1;
          csel      <= SRC1_SEL;
          caddr_rd  <= pix_reg;
        end
        S_RD1: begin
          d1_reg    <= cdata_rd;
          state_reg <= S_WR0;
          crd       <= 1'b0;
          cwr       <= 1'b1;
          csel      <= DST_SEL;
          caddr_wr  <= {pix_reg[AW-2:0], 1'b0};
          cdata_wr  <= d0_reg;
        end
        S_WR0: begin
          state_reg <= S_WR1;
          caddr_wr  <= {pix_reg[AW-2:0], 1'b1};
          cdata_wr  <= d1_reg;
        end
        S_WR1: begin
          cwr <= 1'b0;
          if (pix_reg == PIX_LAST) begin
            state_reg <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pix_reg   <= '0;
          end else begin
            state_reg <= S_RD0;
            pix_reg   <= pix_reg + PIX_ONE;
            crd       <= 1'b1;
            csel      <= SRC0_SEL;
            caddr_rd  <= pix_reg + PIX_ONE;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

`ifdef L2_FLATTEN_CHKSUM_EN
  // Accumulates the words actually on the bus, so it is final as soon as DONE is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chksum <= '0;
    end else if (state_reg == S_IDLE && start) begin
      chksum <= '0;
    end else if (cwr) begin
      chksum <= chksum + {{(32-DW){1'b0}}, cdata_wr};
    end
  end
`endif

endmodule
